// File: rtl/poly_pkg.sv
// Shared types, constants and the saturation helper for the polyphony controller.
package poly_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} poly_state_t;

    localparam int unsigned MULT_W = 32;
    localparam int unsigned DIV_W  = 48;

    // Clamp a signed value to the signed range of a width-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned       width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/poly_voice_alloc.sv
// Combinational voice picker: same-pitch hit, lowest free voice and oldest voice.
module poly_voice_alloc #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned PITCH_W    = 6,
    parameter int unsigned AGE_W      = 8,
    parameter int unsigned IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]              gate_i,
    input  logic [NUM_VOICES-1:0][PITCH_W-1:0] pitch_arr_i,
    input  logic [NUM_VOICES-1:0][AGE_W-1:0]   age_arr_i,
    input  logic [PITCH_W-1:0]                 pitch_i,
    output logic                               hit_o,
    output logic [IDX_W-1:0]                   hit_idx_o,
    output logic                               free_o,
    output logic [IDX_W-1:0]                   free_idx_o,
    output logic [IDX_W-1:0]                   oldest_idx_o
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        hit_o        = 1'b0;
        hit_idx_o    = '0;
        free_o       = 1'b0;
        free_idx_o   = '0;
        oldest_idx_o = '0;
        best_age     = age_arr_i[0];
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (!hit_o && gate_i[i] && (pitch_arr_i[i] == pitch_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
            if (!free_o && !gate_i[i]) begin
                free_o     = 1'b1;
                free_idx_o = IDX_W'(i);
            end
            // Strict compare keeps the lowest index on equal ages.
            if (age_arr_i[i] > best_age) begin
                best_age     = age_arr_i[i];
                oldest_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/poly_voice_ctrl.sv
// N-voice polyphony controller: key allocation, per-frame voice sequencing,
// shared multiplier/divider muxing and saturated mix accumulation.
module poly_voice_ctrl
    import poly_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned WAVE_W     = 24,
    parameter int unsigned FREQ_W     = 24,
    parameter int unsigned PITCH_W    = 6,
    parameter bit          STEAL      = 1'b1,
    parameter int unsigned AGE_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           finish,
    input  logic                           key_press,
    input  logic                           key_release,
    input  logic [PITCH_W-1:0]             pitch,
    input  logic [FREQ_W-1:0]              freq,
    output logic                           key_dropped,
    output logic [NUM_VOICES-1:0]          voice_start,
    input  logic [NUM_VOICES-1:0]          voice_finish,
    input  logic [NUM_VOICES*WAVE_W-1:0]   voice_wave,
    output logic [NUM_VOICES-1:0]          voice_gate,
    output logic [NUM_VOICES-1:0]          voice_trigger,
    output logic [NUM_VOICES*FREQ_W-1:0]   voice_freq,
    input  logic [NUM_VOICES*MULT_W-1:0]   voice_mult_a,
    input  logic [NUM_VOICES*MULT_W-1:0]   voice_mult_b,
    input  logic [NUM_VOICES*DIV_W-1:0]    voice_div_n,
    input  logic [NUM_VOICES*DIV_W-1:0]    voice_div_d,
    output logic [MULT_W-1:0]              mult_a,
    output logic [MULT_W-1:0]              mult_b,
    output logic [DIV_W-1:0]               div_n,
    output logic [DIV_W-1:0]               div_d,
    output logic [WAVE_W-1:0]              mix_out
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam int unsigned ACC_W = WAVE_W + IDX_W;

    poly_state_t                        state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic signed [ACC_W-1:0]            acc_q, acc_d;
    logic [NUM_VOICES-1:0]              gate_q, gate_d, trig_q, trig_d;
    logic [NUM_VOICES-1:0][PITCH_W-1:0] pitch_q, pitch_d;
    logic [NUM_VOICES-1:0][FREQ_W-1:0]  freq_q, freq_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0]   age_q, age_d;
    logic [NUM_VOICES-1:0]              snap_gate_q, snap_gate_d, snap_trig_q, snap_trig_d;
    logic [NUM_VOICES-1:0][FREQ_W-1:0]  snap_freq_q, snap_freq_d;
    logic [WAVE_W-1:0]                  mix_q, mix_d;
    logic                               finish_q, finish_d, dropped_q, dropped_d;

    logic                               hit, free, do_alloc;
    logic [IDX_W-1:0]                   hit_idx, free_idx, oldest_idx, sel_idx;
    logic signed [WAVE_W-1:0]           wave_sel;
    logic signed [ACC_W-1:0]            acc_sum;
    logic signed [63:0]                 acc_wide, acc_sat;
    logic                               unused_sat;

    poly_voice_alloc #(
        .NUM_VOICES (NUM_VOICES),
        .PITCH_W    (PITCH_W),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_alloc (
        .gate_i       (gate_q),
        .pitch_arr_i  (pitch_q),
        .age_arr_i    (age_q),
        .pitch_i      (pitch),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .free_o       (free),
        .free_idx_o   (free_idx),
        .oldest_idx_o (oldest_idx)
    );

    assign wave_sel   = voice_wave[idx_q*WAVE_W +: WAVE_W];
    assign acc_sum    = acc_q + {{IDX_W{wave_sel[WAVE_W-1]}}, wave_sel};
    assign acc_wide   = {{(64-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
    assign acc_sat    = sat_signed(acc_wide, WAVE_W);
    assign unused_sat = ^acc_sat[63:WAVE_W];

    always_comb begin
        do_alloc  = 1'b0;
        sel_idx   = '0;
        dropped_d = 1'b0;
        if (key_press) begin
            if (hit) begin
                do_alloc = 1'b1;
                sel_idx  = hit_idx;
            end else if (free) begin
                do_alloc = 1'b1;
                sel_idx  = free_idx;
            end else if (STEAL) begin
                do_alloc = 1'b1;
                sel_idx  = oldest_idx;
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        gate_d      = gate_q;
        trig_d      = trig_q;
        pitch_d     = pitch_q;
        freq_d      = freq_q;
        age_d       = age_q;
        snap_gate_d = snap_gate_q;
        snap_trig_d = snap_trig_q;
        snap_freq_d = snap_freq_q;
        mix_d       = mix_q;
        finish_d    = 1'b0;
        voice_start = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_gate_d = gate_q;
                    snap_trig_d = trig_q;
                    snap_freq_d = freq_q;
                    trig_d      = '0;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                voice_start[idx_q] = 1'b1;
                if (voice_finish[idx_q]) begin
                    acc_d = acc_sum;
                    if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                        mix_d    = acc_sat[WAVE_W-1:0];
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Key updates come after the snapshot clear so a fresh trigger wins.
        if (do_alloc) begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                if (IDX_W'(v) == sel_idx) begin
                    pitch_d[v] = pitch;
                    freq_d[v]  = freq;
                    gate_d[v]  = 1'b1;
                    trig_d[v]  = 1'b1;
                    age_d[v]   = '0;
                end else if (gate_q[v] && (age_q[v] != {AGE_W{1'b1}})) begin
                    age_d[v] = age_q[v] + 1'b1;
                end
            end
        end else if (key_release && !key_press) begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                if (gate_q[v] && (pitch_q[v] == pitch)) begin
                    gate_d[v] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            gate_q      <= '0;
            trig_q      <= '0;
            pitch_q     <= '0;
            freq_q      <= '0;
            age_q       <= '0;
            snap_gate_q <= '0;
            snap_trig_q <= '0;
            snap_freq_q <= '0;
            mix_q       <= '0;
            finish_q    <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            gate_q      <= gate_d;
            trig_q      <= trig_d;
            pitch_q     <= pitch_d;
            freq_q      <= freq_d;
            age_q       <= age_d;
            snap_gate_q <= snap_gate_d;
            snap_trig_q <= snap_trig_d;
            snap_freq_q <= snap_freq_d;
            mix_q       <= mix_d;
            finish_q    <= finish_d;
            dropped_q   <= dropped_d;
        end
    end

    assign finish        = finish_q;
    assign key_dropped   = dropped_q;
    assign voice_gate    = snap_gate_q;
    assign voice_trigger = snap_trig_q;
    assign voice_freq    = snap_freq_q;
    assign mix_out       = mix_q;
    assign mult_a        = voice_mult_a[idx_q*MULT_W +: MULT_W];
    assign mult_b        = voice_mult_b[idx_q*MULT_W +: MULT_W];
    assign div_n         = voice_div_n[idx_q*DIV_W +: DIV_W];
    assign div_d         = voice_div_d[idx_q*DIV_W +: DIV_W];

endmodule

// File: tb/tb_poly_voice_ctrl.sv
// Bench for poly_voice_ctrl: a stealing and a dropping instance share stimulus;
// frame results go through a scoreboard queue checked on each finish pulse.
module tb_poly_voice_ctrl;

    localparam int NV = 4;
    localparam int WW = 24;
    localparam int FW = 24;
    localparam int PW = 6;

    typedef struct {
        logic [NV-1:0] gate;
        logic [NV-1:0] trig;
        logic [WW-1:0] mix;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clk = 1'b0;
    logic rst, start, key_press, key_release;
    logic [PW-1:0] pitch;
    logic [FW-1:0] freq;
    logic [NV-1:0] voice_finish;
    logic signed [WW-1:0] wave_v [NV];
    logic [NV*WW-1:0] voice_wave;
    logic [NV*32-1:0] vm_a, vm_b;
    logic [NV*48-1:0] vd_n, vd_d;

    logic fin_s, kd_s, fin_d, kd_d;
    logic [NV-1:0] vs_s, vg_s, vt_s, vs_d, vg_d, vt_d;
    logic [NV*FW-1:0] vf_s, vf_d;
    logic [31:0] ma_s, mb_s, ma_d, mb_d;
    logic [47:0] dn_s, dd_s, dn_d, dd_d;
    logic [WW-1:0] mix_s, mix_d;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NV; k++) voice_wave[k*WW +: WW] = wave_v[k];
    end

    poly_voice_ctrl #(.NUM_VOICES(NV), .WAVE_W(WW), .FREQ_W(FW), .PITCH_W(PW),
                      .STEAL(1'b1), .AGE_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .finish(fin_s),
        .key_press(key_press), .key_release(key_release), .pitch(pitch), .freq(freq),
        .key_dropped(kd_s), .voice_start(vs_s), .voice_finish(voice_finish),
        .voice_wave(voice_wave), .voice_gate(vg_s), .voice_trigger(vt_s),
        .voice_freq(vf_s), .voice_mult_a(vm_a), .voice_mult_b(vm_b),
        .voice_div_n(vd_n), .voice_div_d(vd_d), .mult_a(ma_s), .mult_b(mb_s),
        .div_n(dn_s), .div_d(dd_s), .mix_out(mix_s)
    );

    poly_voice_ctrl #(.NUM_VOICES(NV), .WAVE_W(WW), .FREQ_W(FW), .PITCH_W(PW),
                      .STEAL(1'b0), .AGE_W(8)) u_dut_drop (
        .clk(clk), .rst(rst), .start(start), .finish(fin_d),
        .key_press(key_press), .key_release(key_release), .pitch(pitch), .freq(freq),
        .key_dropped(kd_d), .voice_start(vs_d), .voice_finish(voice_finish),
        .voice_wave(voice_wave), .voice_gate(vg_d), .voice_trigger(vt_d),
        .voice_freq(vf_d), .voice_mult_a(vm_a), .voice_mult_b(vm_b),
        .voice_div_n(vd_n), .voice_div_d(vd_d), .mult_a(ma_d), .mult_b(mb_d),
        .div_n(dn_d), .div_d(dd_d), .mix_out(mix_d)
    );

    function automatic logic [FW-1:0] fslot(input logic [NV*FW-1:0] v, input int k);
        return v[k*FW +: FW];
    endfunction

    function automatic logic [WW-1:0] ref_mix();
        longint s = 0;
        logic [63:0] r;
        for (int k = 0; k < NV; k++) s += longint'(wave_v[k]);
        if (s > 64'sd8388607) s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
        r = s;
        return r[WW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [PW-1:0] p, input logic [FW-1:0] f);
        key_press = 1'b1;
        pitch     = p;
        freq      = f;
        tick();
        key_press = 1'b0;
    endtask

    task automatic release_key(input logic [PW-1:0] p);
        key_release = 1'b1;
        pitch       = p;
        tick();
        key_release = 1'b0;
    endtask

    // One frame; voice k finishes k+2 cycles after it starts, with a stray
    // finish on the next voice during each wait.
    task automatic run_frame(input logic [NV-1:0] eg, input logic [NV-1:0] et,
                             input bit hold_start, input bit press_now,
                             input logic [PW-1:0] p, input logic [FW-1:0] f);
        exp_t e;
        int   cyc;
        e.gate = eg;
        e.trig = et;
        e.mix  = ref_mix();
        sb_q.push_back(e);
        start = 1'b1;
        if (press_now) begin
            key_press = 1'b1;
            pitch     = p;
            freq      = f;
        end
        tick();
        key_press = 1'b0;
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < NV; k++) begin
            for (int d = 0; d < k + 2; d++) begin
                n_tests++;
                if (vs_s !== NV'(1 << k)) begin
                    n_fail++;
                    $display("FAIL voice_start_order v%0d: got %b want %b", k, vs_s, NV'(1 << k));
                end
                if (d == 0) voice_finish[(k + 1) % NV] = 1'b1;
                tick();
                voice_finish = '0;
            end
            n_tests++;
            if (ma_s !== (32'hA500_0000 | 32'(k)) || dd_s !== (48'hD0_0000_0000 + 48'(k))) begin
                n_fail++;
                $display("FAIL shared_mux v%0d: got mult_a %h div_d %h", k, ma_s, dd_s);
            end
            voice_finish[k] = 1'b1;
            tick();
            voice_finish = '0;
        end
        start = 1'b0;
        cyc = 0;
        while (fin_s !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
        e = sb_q.pop_front();
        n_tests++;
        if (fin_s !== 1'b1 || cyc != 0) begin
            n_fail++;
            $display("FAIL finish_latency: got finish %b after %0d extra cycles want 1 after 0",
                     fin_s, cyc);
        end else begin
            n_tests++;
            if (vg_s !== e.gate || vt_s !== e.trig) begin
                n_fail++;
                $display("FAIL frame_snapshot: got gate %b trig %b want gate %b trig %b",
                         vg_s, vt_s, e.gate, e.trig);
            end
            n_tests++;
            if (mix_s !== e.mix || fin_d !== 1'b1) begin
                n_fail++;
                $display("FAIL frame_mix: got %h (drop finish %b) want %h", mix_s, fin_d, e.mix);
            end
        end
        tick();
        n_tests++;
        if (fin_s !== 1'b0 || vs_s !== '0) begin
            n_fail++;
            $display("FAIL finish_pulse_width: got finish %b voice_start %b want 0 0", fin_s, vs_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (fin_s !== 1'b0 || kd_s !== 1'b0 || vs_s !== '0 || fin_d !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got finish %b dropped %b vstart %b", fin_s, kd_s, vs_s);
        end
        n_tests++;
        if (vg_s !== '0 || vt_s !== '0 || vf_s !== '0 || mix_s !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gate %b trig %b freq %h mix %h want 0",
                     vg_s, vt_s, vf_s, mix_s);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alloc_order();
        press(6'd10, 24'h000100);
        press(6'd11, 24'h000200);
        press(6'd12, 24'h000300);
        wave_v[0] = 24'sd5;
        wave_v[1] = -24'sd3;
        wave_v[2] = 24'sd0;
        wave_v[3] = 24'sd1;
        run_frame(4'b0111, 4'b0111, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < NV; k++) begin
            n_tests++;
            if (fslot(vf_s, k) !== ((k < 3) ? FW'((k + 1) * 'h100) : '0)) begin
                n_fail++;
                $display("FAIL alloc_freq v%0d: got %h want %h", k, fslot(vf_s, k),
                         (k < 3) ? FW'((k + 1) * 'h100) : '0);
            end
        end
        n_tests++;
        if (vt_d !== 4'b0111) begin
            n_fail++;
            $display("FAIL alloc_drop_inst: got trig %b want 0111", vt_d);
        end
    endtask

    task automatic test_retrigger();
        for (int k = 0; k < NV; k++) wave_v[k] = '0;
        press(6'd10, 24'h001000);
        run_frame(4'b0111, 4'b0001, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (fslot(vf_s, 0) !== 24'h001000 || fslot(vf_s, 1) !== 24'h000200) begin
            n_fail++;
            $display("FAIL retrigger_freq: got %h %h want 001000 000200",
                     fslot(vf_s, 0), fslot(vf_s, 1));
        end
        // Age of voice 0 was reset by the retrigger, so voice 1 is now oldest.
        press(6'd13, 24'h000400);
        press(6'd20, 24'h000500);
        n_tests++;
        if (kd_s !== 1'b0 || kd_d !== 1'b1) begin
            n_fail++;
            $display("FAIL retrig_drop_pulse: got steal %b drop %b want 0 1", kd_s, kd_d);
        end
        run_frame(4'b1111, 4'b1010, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (fslot(vf_s, 1) !== 24'h000500 || fslot(vf_s, 0) !== 24'h001000) begin
            n_fail++;
            $display("FAIL retrig_steal_oldest: got v0 %h v1 %h want 001000 000500",
                     fslot(vf_s, 0), fslot(vf_s, 1));
        end
        n_tests++;
        if (fslot(vf_d, 1) !== 24'h000200 || vt_d !== 4'b1000 || vg_d !== 4'b1111) begin
            n_fail++;
            $display("FAIL retrig_drop_state: got v1 %h trig %b gate %b want 000200 1000 1111",
                     fslot(vf_d, 1), vt_d, vg_d);
        end
    endtask

    task automatic test_steal_drop();
        release_key(6'd10);
        release_key(6'd11);
        release_key(6'd12);
        release_key(6'd13);
        release_key(6'd20);
        for (int k = 1; k <= NV; k++) press(PW'(k), FW'(k * 'h11));
        press(6'd5, 24'h000555);
        n_tests++;
        if (kd_s !== 1'b0 || kd_d !== 1'b1) begin
            n_fail++;
            $display("FAIL steal_drop_pulse: got steal %b drop %b want 0 1", kd_s, kd_d);
        end
        tick();
        n_tests++;
        if (kd_d !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_pulse_width: got %b want 0", kd_d);
        end
        run_frame(4'b1111, 4'b1111, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (fslot(vf_s, 0) !== 24'h000555 || fslot(vf_s, 1) !== 24'h000022) begin
            n_fail++;
            $display("FAIL steal_oldest: got v0 %h v1 %h want 000555 000022",
                     fslot(vf_s, 0), fslot(vf_s, 1));
        end
        n_tests++;
        if (fslot(vf_d, 0) !== 24'h000011 || vt_d !== 4'b1111) begin
            n_fail++;
            $display("FAIL drop_unchanged: got v0 %h trig %b want 000011 1111",
                     fslot(vf_d, 0), vt_d);
        end
    endtask

    task automatic test_mix_sat();
        for (int k = 0; k < NV; k++) wave_v[k] = 24'h7FFFFF;
        run_frame(4'b1111, 4'b0000, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < NV; k++) wave_v[k] = 24'h800000;
        run_frame(4'b1111, 4'b0000, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        wave_v[0] = 24'sd100;
        wave_v[1] = 24'sd200;
        wave_v[2] = -24'sd50;
        wave_v[3] = 24'sd7;
        run_frame(4'b1111, 4'b0000, 1'b1, 1'b0, '0, '0);
        tick();
        tick();
        n_tests++;
        if (vs_s !== '0 || fin_s !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_frame: got vstart %b finish %b want 0 0", vs_s, fin_s);
        end
    endtask

    task automatic test_edge_events();
        for (int k = 1; k <= 5; k++) release_key(PW'(k));
        run_frame(4'b0000, 4'b0000, 1'b0, 1'b1, 6'd30, 24'h000777);
        run_frame(4'b0001, 4'b0001, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (fslot(vf_s, 0) !== 24'h000777) begin
            n_fail++;
            $display("FAIL press_with_start_freq: got %h want 000777", fslot(vf_s, 0));
        end
        key_press   = 1'b1;
        key_release = 1'b1;
        pitch       = 6'd30;
        freq        = 24'h000888;
        tick();
        key_press   = 1'b0;
        key_release = 1'b0;
        run_frame(4'b0001, 4'b0001, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (fslot(vf_s, 0) !== 24'h000888) begin
            n_fail++;
            $display("FAIL press_release_freq: got %h want 000888", fslot(vf_s, 0));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (vs_s !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_frame_entry: got vstart %b want 0001", vs_s);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (vs_s !== '0 || vg_s !== '0 || mix_s !== '0 || fin_s !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_frame: got vstart %b gate %b mix %h finish %b want 0",
                     vs_s, vg_s, mix_s, fin_s);
        end
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 4; c++) begin
                tick();
                seen |= fin_s | (|vs_s);
            end
            n_tests++;
            if (seen !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_finish: got activity %b want 0", seen);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        key_press    = 1'b0;
        key_release  = 1'b0;
        pitch        = '0;
        freq         = '0;
        voice_finish = '0;
        for (int k = 0; k < NV; k++) begin
            wave_v[k]            = '0;
            vm_a[k*32 +: 32]     = 32'hA500_0000 | 32'(k);
            vm_b[k*32 +: 32]     = 32'h5A00_0000 | 32'(k);
            vd_n[k*48 +: 48]     = 48'h00_1234_0000 + 48'(k);
            vd_d[k*48 +: 48]     = 48'hD0_0000_0000 + 48'(k);
        end
        test_reset();
        test_alloc_order();
        test_retrigger();
        test_steal_drop();
        test_mix_sat();
        test_back_to_back();
        test_edge_events();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
